// File: rtl/delay_line_mem.sv
// Circular delay line over an inferred block RAM. Each sample strobe writes
// one sample. The same strobe returns, one clock later, the sample written
// `delay` strobes earlier. Slots that have not been filled since reset or
// clear read as zero.
module delay_line_mem #(
  parameter int WIDTH     = 12,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [WIDTH-1:0]     sample_in,
  input  logic [ADDR_BITS-1:0] delay,
  input  logic                 clear,
  output logic [WIDTH-1:0]     sample_out,
  output logic                 out_valid,
  output logic [ADDR_BITS-1:0] fill
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  // Source of the registered output. The output is a register-fed mux, so the
  // RAM read data register can stay in the block RAM primitive.
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_BYP  = 2'd1,
    SEL_RAM  = 2'd2
  } sel_e;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [WIDTH-1:0]     rd_q;

  logic [ADDR_BITS-1:0] wptr_q, wptr_d;
  logic [ADDR_BITS-1:0] fill_q, fill_d;
  logic [WIDTH-1:0]     byp_q, byp_d;
  sel_e                 sel_q, sel_d;
  logic                 vld_q, vld_d;

  logic                 wr_en;
  logic [ADDR_BITS-1:0] raddr;

  // A strobe is accepted only when neither reset nor clear is asserted.
  assign wr_en = sample_valid & ~clear & ~reset;
  // Modulo-DEPTH subtraction: wraps naturally in ADDR_BITS bits.
  assign raddr = wptr_q - delay;

  // Next-state logic for pointers, fill level and output source selection.
  always_comb begin
    wptr_d = wptr_q;
    fill_d = fill_q;
    byp_d  = byp_q;
    sel_d  = sel_q;
    vld_d  = 1'b0;
    if (clear) begin
      // Flush history; a coincident strobe is discarded.
      wptr_d = '0;
      fill_d = '0;
      sel_d  = SEL_ZERO;
    end else if (sample_valid) begin
      wptr_d = wptr_q + ADDR_BITS'(1);
      if (fill_q != {ADDR_BITS{1'b1}}) begin
        fill_d = fill_q + ADDR_BITS'(1);
      end
      vld_d = 1'b1;
      if (delay == '0) begin
        // Zero delay bypasses the RAM entirely.
        sel_d = SEL_BYP;
        byp_d = sample_in;
      end else if (delay <= fill_q) begin
        sel_d = SEL_RAM;
      end else begin
        // Requested history has not been written yet.
        sel_d = SEL_ZERO;
      end
    end
  end

  // State registers with synchronous reset; memory contents are masked by fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      fill_q <= '0;
      byp_q  <= '0;
      sel_q  <= SEL_ZERO;
      vld_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      fill_q <= fill_d;
      byp_q  <= byp_d;
      sel_q  <= sel_d;
      vld_q  <= vld_d;
    end
  end

  // Block RAM: write at wptr, synchronous read of old contents at raddr.
  // raddr differs from wptr whenever the RAM data is actually used.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_q] <= sample_in;
      rd_q        <= mem[raddr];
    end
  end

  // Output selection from registered sources only; holds between strobes.
  always_comb begin
    sample_out = '0;
    case (sel_q)
      SEL_BYP: sample_out = byp_q;
      SEL_RAM: sample_out = rd_q;
      default: sample_out = '0;
    endcase
  end

  assign out_valid = vld_q;
  assign fill      = fill_q;

endmodule
